// File: rtl/blood_splat_render.sv
// Blood-splat sprite overlay: maps VGA pixels into a 64x64 ROM window at a latched hit position
// and mixes opaque sprite pixels over the background for a fixed number of frames, fading at the end.
module blood_splat_render #(
    parameter int          FRAMES_ON   = 30,
    parameter int          FADE_FRAMES = 8,
    parameter logic [11:0] TRANSP      = 12'h000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        hit,
    input  logic [9:0]  hit_x,
    input  logic [9:0]  hit_y,
    input  logic        frame_tick,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic        video_on,
    input  logic [11:0] bg_rgb,
    output logic [5:0]  rom_row,
    output logic [5:0]  rom_col,
    input  logic [11:0] rom_data,
    output logic [11:0] rgb_out,
    output logic        video_on_out,
    output logic        busy
);
    localparam int             CW      = $clog2(FRAMES_ON + 1);
    localparam logic [CW-1:0]  LAST    = CW'(FRAMES_ON - 1);
    localparam logic [CW-1:0]  FADE_AT = CW'(FRAMES_ON - FADE_FRAMES);

    typedef enum logic [1:0] {IDLE, ARMED, SHOW} state_t;

    state_t        state;
    logic [CW-1:0] frame_cnt;
    logic          pend;
    logic [9:0]    shadow_x, shadow_y, live_x, live_y;

    // Shadow/live split keeps the sprite from moving mid-frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            frame_cnt <= '0;
            pend      <= 1'b0;
            shadow_x  <= '0;
            shadow_y  <= '0;
            live_x    <= '0;
            live_y    <= '0;
        end else begin
            if (hit) begin
                shadow_x <= hit_x;
                shadow_y <= hit_y;
            end
            // A tick consumes an older pending hit; a same-cycle hit stays pending for the next tick.
            pend <= (frame_tick && pend) ? hit : (pend | hit);
            case (state)
                IDLE: if (hit) state <= ARMED;
                ARMED: if (frame_tick) begin
                    state     <= SHOW;
                    live_x    <= shadow_x;
                    live_y    <= shadow_y;
                    frame_cnt <= '0;
                end
                SHOW: if (frame_tick) begin
                    if (pend) begin
                        live_x    <= shadow_x;
                        live_y    <= shadow_y;
                        frame_cnt <= '0;
                    end else if (frame_cnt == LAST) begin
                        frame_cnt <= '0;
                        state     <= hit ? ARMED : IDLE;
                    end else begin
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

    // Unsigned wrap makes pixels left of / above the box land far outside it.
    logic [10:0] dx, dy;
    logic        in_box;
    assign dx      = {1'b0, pix_x} - {1'b0, live_x};
    assign dy      = {1'b0, pix_y} - {1'b0, live_y};
    assign in_box  = (dx < 11'd64) && (dy < 11'd64);
    assign rom_row = dy[5:0];
    assign rom_col = dx[5:0];

    logic        show_d1, vid_d1;
    logic [11:0] bg_d1, mix;
    logic [3:0]  red;

    always_comb begin
        red = (frame_cnt >= FADE_AT) ? {1'b0, rom_data[11:9]} : rom_data[11:8];
        mix = bg_d1;
        if (!vid_d1)
            mix = 12'h000;
        else if (show_d1 && rom_data != TRANSP)
            mix = {red, rom_data[7:0]};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            show_d1      <= 1'b0;
            vid_d1       <= 1'b0;
            bg_d1        <= '0;
            rgb_out      <= '0;
            video_on_out <= 1'b0;
        end else begin
            show_d1      <= in_box && (state == SHOW);
            vid_d1       <= video_on;
            bg_d1        <= bg_rgb;
            rgb_out      <= mix;
            video_on_out <= vid_d1;
        end
    end
endmodule
